// File: rtl/hcsr04_emulator.sv
// hcsr04_emulator: responder-side HC-SR04 model returning an echo pulse whose width encodes distance_cm
// Ports: CLOCK_50 clock; reset synchronous active-low; trig asynchronous trigger from the initiator;
//   distance_cm simulated target distance in cm; echo registered echo pulse; busy high outside IDLE;
//   ping_count accepted requests (wraps 255->0).
// Optional: define HCSR04_JITTER_EN to add 0-255 cycles of LFSR noise to each echo width.
module hcsr04_emulator #(
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_CYCLES    = 10000,
  parameter int CYCLES_PER_CM   = 2900,
  parameter int MIN_CM          = 2,
  parameter int MAX_CM          = 400,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic [7:0] ping_count
);
  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;
  state_t state, state_n;
  logic trig_m, trig_s, trig_prev, trig_rise;
  logic [23:0] cnt, cnt_n;
  logic [20:0] width, width_n, base_width, jitter;
  logic echo_n;
  logic [7:0] ping_n;
`ifdef HCSR04_JITTER_EN
  logic [15:0] lfsr;
  always_ff @(posedge CLOCK_50)
    lfsr <= !reset ? 16'hACE1 : {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign jitter = {13'd0, lfsr[7:0]};
`else
  assign jitter = '0;
`endif
  assign trig_rise = trig_s & ~trig_prev;
  assign busy = state != IDLE;
  assign base_width = distance_cm < 9'(MIN_CM) ? 21'(MIN_CM * CYCLES_PER_CM) :
                      distance_cm > 9'(MAX_CM) ? 21'(TIMEOUT_CYCLES) :
                      21'(distance_cm) * 21'(CYCLES_PER_CM);
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      trig_m     <= 1'b0;
      trig_s     <= 1'b0;
      trig_prev  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      width      <= '0;
      echo       <= 1'b0;
      ping_count <= '0;
    end else begin
      trig_m     <= trig;
      trig_s     <= trig_m;
      trig_prev  <= trig_s;
      state      <= state_n;
      cnt        <= cnt_n;
      width      <= width_n;
      echo       <= echo_n;
      ping_count <= ping_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    width_n = width;
    echo_n  = echo;
    ping_n  = ping_count;
    case (state)
      IDLE:
        if (trig_rise) begin
          state_n = TRIG_HI;
          cnt_n   = 24'd1;
        end
      TRIG_HI:
        if (trig_s)
          cnt_n = &cnt ? cnt : cnt + 24'd1;
        else if (cnt >= 24'(MIN_TRIG_CYCLES)) begin
          state_n = BURST;
          cnt_n   = '0;
          width_n = base_width + jitter;
          ping_n  = ping_count + 8'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      BURST:
        if (cnt == 24'(BURST_CYCLES - 1)) begin
          state_n = ECHO;
          cnt_n   = '0;
          echo_n  = 1'b1;
        end else
          cnt_n = cnt + 24'd1;
      ECHO:
        if (cnt == 24'(width) - 24'd1) begin
          state_n = HOLDOFF;
          cnt_n   = '0;
          echo_n  = 1'b0;
        end else
          cnt_n = cnt + 24'd1;
      HOLDOFF:
        if (cnt == 24'(HOLDOFF_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else
          cnt_n = cnt + 24'd1;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        echo_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_hcsr04_emulator.sv
// tb_hcsr04_emulator: scoreboard bench for hcsr04_emulator with scaled-down timing parameters
module tb_hcsr04_emulator;
  localparam int MIN = 20, B = 50, CPCM = 3, MINCM = 2, MAXCM = 400, TO = 1500, H = 100;
  logic clk = 1'b0, reset = 1'b0, trig = 1'b0;
  logic [8:0] distance_cm = '0;
  logic echo, busy;
  logic [7:0] ping_count;
  typedef struct {int rise; int width; int ping;} exp_t;
  exp_t q[$];
  exp_t cur;
  int cyc = 0, errs = 0, checks = 0, rise_c = 0, fall_c = 0, exp_ping = 0;
  bit in_echo = 0, have = 0, pend_busy = 0;
  int seen[$];
  hcsr04_emulator #(
    .MIN_TRIG_CYCLES(MIN), .BURST_CYCLES(B), .CYCLES_PER_CM(CPCM), .MIN_CM(MINCM),
    .MAX_CM(MAXCM), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(H)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .ping_count(ping_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic req(int n, int d, int w);
    exp_t e;
    distance_cm = 9'(d);
    trig = 1'b1;
    tick(n);
    trig = 1'b0;
    if (n >= MIN) begin
      exp_ping = (exp_ping + 1) % 256;
      e.rise = cyc + 3 + B;
      e.width = w;
      e.ping = exp_ping;
      q.push_back(e);
    end
  endtask
  task automatic settle();
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      ok = !busy && !pend_busy && !in_echo && q.size() == 0;
      if (!ok) tick(1);
    end
    if (!ok) chk("settle_timeout", 1, 0);
  endtask
  task automatic wait_echo();
    for (int i = 0; i < 3000 && !echo; i++) tick(1);
    if (!echo) chk("echo_timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      in_echo = 0;
      pend_busy = 0;
      have = 0;
    end else begin
      if (echo && !in_echo) begin
        in_echo = 1;
        rise_c = cyc;
        have = q.size() != 0;
        if (!have) chk("unexpected_echo", 1, 0);
        else begin
          cur = q.pop_front();
          chk("echo_rise_cycle", rise_c, cur.rise);
          chk("ping_count", int'(ping_count), cur.ping);
        end
      end else if (!echo && in_echo) begin
        in_echo = 0;
        if (have) begin
`ifdef HCSR04_JITTER_EN
          chk("echo_width_range", int'(cyc - rise_c >= cur.width && cyc - rise_c <= cur.width + 255), 1);
          seen.push_back(cyc - rise_c);
`else
          chk("echo_width", cyc - rise_c, cur.width);
`endif
          pend_busy = 1;
          fall_c = cyc;
        end
      end
      if (pend_busy && !busy) begin
        pend_busy = 0;
        chk("busy_fall_delay", cyc - fall_c, H);
      end
    end
  end
  initial begin
    tick(3);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ping", int'(ping_count), 0);
    reset = 1'b1;
    tick(2);
    req(15, 10, 0);
    tick(4);
    chk("runt_busy", int'(busy), 0);
    chk("runt_ping", int'(ping_count), 0);
    settle();
    req(19, 10, 0);
    tick(4);
    chk("short_by_one_ping", int'(ping_count), 0);
    settle();
    req(20, 10, 30);
    settle();
    req(30, 10, 30);
    settle();
    req(30, 450, 1500);
    settle();
    req(30, 0, 6);
    settle();
    req(30, 400, 1200);
    settle();
    req(30, 1, 6);
    settle();
    req(30, 2, 6);
    settle();
    req(30, 401, 1500);
    settle();
    req(30, 10, 30);
    wait_echo();
    distance_cm = 9'd300;
    trig = 1'b1;
    tick(30);
    trig = 1'b0;
    tick(40);
    trig = 1'b1;
    for (int i = 0; i < 500 && busy; i++) tick(1);
    tick(50);
    chk("held_trig_busy", int'(busy), 0);
    chk("held_trig_ping", int'(ping_count), exp_ping);
    trig = 1'b0;
    tick(5);
    req(30, 10, 30);
    settle();
    req(30, 400, 1200);
    wait_echo();
    tick(10);
    reset = 1'b0;
    tick(1);
    chk("midecho_rst_echo", int'(echo), 0);
    chk("midecho_rst_busy", int'(busy), 0);
    chk("midecho_rst_ping", int'(ping_count), 0);
    exp_ping = 0;
    q.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    tick(2);
    req(30, 10, 30);
    settle();
`ifdef HCSR04_JITTER_EN
    begin
      int distinct = 0;
      seen.delete();
      for (int k = 0; k < 20; k++) begin
        req(30, 10, 30);
        settle();
      end
      foreach (seen[k]) if (seen[k] != seen[0]) distinct = 1;
      chk("jitter_distinct", distinct, 1);
      chk("jitter_count", seen.size(), 20);
    end
`endif
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
